// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer with an optional pedestrian walk phase.
// The walk phase is built only when TRAFFIC_PED_WALK_EN is defined.
module traffic_light_ctrl #(
  parameter int G_MAIN_MIN = 8,
  parameter int G_SIDE     = 6,
  parameter int Y_TIME     = 3,
  parameter int RED_CLR    = 1,
  parameter int WALK_TIME  = 5,
  parameter int TW         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_side,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    WALK        = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_B   = 3'd6,
    ILLEGAL     = 3'd7
  } state_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Timer load value is duration-1; a zero duration behaves as one cycle.
  function automatic logic [TW-1:0] load_val(input state_e s);
    int d;
    case (s)
      MAIN_GREEN:               d = G_MAIN_MIN;
      MAIN_YELLOW, SIDE_YELLOW: d = Y_TIME;
      WALK:                     d = WALK_TIME;
      SIDE_GREEN:               d = G_SIDE;
      default:                  d = RED_CLR;
    endcase
    return (d <= 1) ? '0 : TW'(d - 1);
  endfunction

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ped_pend_q, ped_pend_d;
  logic          done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= MAIN_GREEN;
      timer_q    <= load_val(MAIN_GREEN);
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    done    = (timer_q == '0);
    case (state_q)
      MAIN_GREEN:  if (done && (car_side || ped_pend_q)) state_d = MAIN_YELLOW;
      MAIN_YELLOW: if (done) state_d = ALL_RED_A;
      ALL_RED_A:   if (done) state_d = ped_pend_q ? WALK
                                     : (car_side ? SIDE_GREEN : ALL_RED_B);
      WALK:        if (done) state_d = car_side ? SIDE_GREEN : ALL_RED_B;
      SIDE_GREEN:  if (done) state_d = SIDE_YELLOW;
      SIDE_YELLOW: if (done) state_d = ALL_RED_B;
      ALL_RED_B:   if (done) state_d = MAIN_GREEN;
      default:     state_d = ALL_RED_B;
    endcase
    // Main green with no demand parks the timer at zero.
    if (state_d != state_q) timer_d = load_val(state_d);
    else if (!done)         timer_d = timer_q - 1'b1;
  end

`ifdef TRAFFIC_PED_WALK_EN
  // Entering WALK serves the request, so clear beats a coincident set.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (state_d == WALK && state_q != WALK) ped_pend_d = 1'b0;
    else if (ped_req && state_q != WALK)    ped_pend_d = 1'b1;
  end
  assign walk = (state_q == WALK);
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_pend_d     = 1'b0;
  assign walk           = 1'b0;
`endif

  always_comb begin
    main_light = LAMP_R;
    side_light = LAMP_R;
    case (state_q)
      MAIN_GREEN:  main_light = LAMP_G;
      MAIN_YELLOW: main_light = LAMP_Y;
      SIDE_GREEN:  side_light = LAMP_G;
      SIDE_YELLOW: side_light = LAMP_Y;
      default: ;
    endcase
  end

  assign ped_pending = ped_pend_q;
  assign state       = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: per-cycle reference model plus literal phase checks.
module tb_traffic_light_ctrl;

`ifdef TRAFFIC_PED_WALK_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       car_side = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light, side_light, state;
  logic       walk, ped_pending;

  traffic_light_ctrl dut (
    .clk(clk), .rst(rst), .car_side(car_side), .ped_req(ped_req),
    .main_light(main_light), .side_light(side_light), .walk(walk),
    .ped_pending(ped_pending), .state(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Reference model: phase name plus cycles spent in it.
  int m_st = 0;
  int m_cnt = 0;
  bit m_pend = 1'b0;

  function automatic int dur(input int s);
    int d;
    case (s)
      0: d = 8; 1: d = 3; 2: d = 1; 3: d = 5; 4: d = 6; 5: d = 3; default: d = 1;
    endcase
    return d;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st = 0; m_cnt = 0; m_pend = 1'b0; cyc = 0;
    end else begin
      int nx;
      bit dn;
      dn = (m_cnt + 1 >= dur(m_st));
      nx = m_st;
      if (dn) begin
        case (m_st)
          0: if (car_side || m_pend) nx = 1;
          1: nx = 2;
          2: nx = m_pend ? 3 : (car_side ? 4 : 6);
          3: nx = car_side ? 4 : 6;
          4: nx = 5;
          5: nx = 6;
          default: nx = 0;
        endcase
      end
      if (PED_EN) begin
        if (nx == 3 && m_st != 3) m_pend = 1'b0;
        else if (ped_req && m_st != 3) m_pend = 1'b1;
      end
      m_cnt = (nx != m_st) ? 0 : m_cnt + 1;
      m_st = nx;
      cyc++;
    end
  end

  function automatic logic [2:0] m_main(input int s);
    return (s == 0) ? 3'b001 : (s == 1) ? 3'b010 : 3'b100;
  endfunction
  function automatic logic [2:0] m_side(input int s);
    return (s == 4) ? 3'b001 : (s == 5) ? 3'b010 : 3'b100;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      logic [9:0] exp_v, got_v;
      exp_v = {3'(m_st), m_main(m_st), m_side(m_st), (m_st == 3), m_pend};
      got_v = {state, main_light, side_light, walk, ped_pending};
      n_chk++;
      if (got_v === exp_v) n_pass++;
      else $display("FAIL model cyc=%0d got st=%0d m=%b s=%b w=%b p=%b want st=%0d m=%b s=%b w=%b p=%b",
                    cyc, got_v[9:7], got_v[6:4], got_v[3:1], got_v[1], got_v[0],
                    exp_v[9:7], exp_v[6:4], exp_v[3:1], exp_v[1], exp_v[0]);
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, exp);
  endtask

  task automatic goto(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) chk("goto_timeout", 8'(cyc), 8'(c));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; car_side = 1'b0; ped_req = 1'b0;
    @(negedge clk);
    #1 chk("rst_state", {5'b0, state}, 8'd0);
    chk("rst_lights", {2'b0, main_light, side_light}, {2'b0, 3'b001, 3'b100});
    chk("rst_ped", {6'b0, walk, ped_pending}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Idle: no demand holds main green.
    do_reset();
    goto(50);
    chk("idle_state", {5'b0, state}, 8'd0);
    chk("idle_lights", {2'b0, main_light, side_light}, {2'b0, 3'b001, 3'b100});

    // Side-road car: full 22-cycle loop.
    do_reset();
    goto(2); car_side = 1'b1;
    goto(7);  chk("car_mg_end", {5'b0, state}, 8'd0);
    goto(8);  chk("car_my", {5'b0, state}, 8'd1);
    goto(11); chk("car_ara", {5'b0, state}, 8'd2);
    goto(12); chk("car_sg", {5'b0, state}, 8'd4);
    chk("car_sg_lights", {2'b0, main_light, side_light}, {2'b0, 3'b100, 3'b001});
    goto(18); chk("car_sy", {5'b0, state}, 8'd5);
    goto(21); chk("car_arb", {5'b0, state}, 8'd6);
    goto(22); chk("car_mg2", {5'b0, state}, 8'd0);
    goto(29); chk("car_mg2_end", {5'b0, state}, 8'd0);
    goto(30); chk("car_my2", {5'b0, state}, 8'd1);

    // Pedestrian pulse at cycle 3, no car.
    do_reset();
    goto(3); ped_req = 1'b1;
    goto(4); ped_req = 1'b0;
`ifdef TRAFFIC_PED_WALK_EN
    chk("ped_pend_set", {7'b0, ped_pending}, 8'd1);
    goto(8);  chk("ped_my", {5'b0, state}, 8'd1);
    goto(11); chk("ped_ara", {5'b0, state}, 8'd2);
    goto(12); chk("ped_walk", {5'b0, state, walk, ped_pending}, {5'b0, 3'd3, 1'b1, 1'b0});
    goto(16); chk("ped_walk_end", {6'b0, walk, ped_pending}, 8'b10);
    goto(17); chk("ped_arb", {5'b0, state}, 8'd6);
    goto(18); chk("ped_mg", {5'b0, state}, 8'd0);

    // Pedestrian and car together; second press during WALK is dropped.
    do_reset();
    goto(3); ped_req = 1'b1; car_side = 1'b1;
    goto(4); ped_req = 1'b0;
    goto(12); chk("pc_walk", {5'b0, state}, 8'd3);
    goto(14); ped_req = 1'b1;
    goto(15); ped_req = 1'b0;
    chk("pc_walk_press", {7'b0, ped_pending}, 8'd0);
    goto(17); chk("pc_sg", {5'b0, state, ped_pending}, {4'b0, 3'd4, 1'b0});
    goto(22); chk("pc_sg_end", {5'b0, state}, 8'd4);
    goto(23); chk("pc_sy", {5'b0, state}, 8'd5);
`else
    chk("nop_pend", {7'b0, ped_pending}, 8'd0);
    goto(50);
    chk("nop_state", {5'b0, state, walk, ped_pending}, 8'd0);
`endif

    // Async reset in the middle of side green.
    do_reset();
    car_side = 1'b1;
    goto(14);
    chk("mid_sg", {5'b0, state}, 8'd4);
    #2 rst = 1'b0;
    #1 chk("async_lights", {2'b0, main_light, side_light}, {2'b0, 3'b001, 3'b100});
    chk("async_walk_state", {4'b0, state, walk}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    goto(7); chk("rel_mg_end", {5'b0, state}, 8'd0);
    goto(8); chk("rel_my", {5'b0, state}, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Sequencing controller for a two-road intersection with a pedestrian crossing. It consumes the single-cycle press pulse produced by the button-press FSM and a side-road vehicle sensor. It steps main-road, side-road and walk signals through timed phases. It sits directly downstream of the button-press FSM and drives the simulated lamp outputs.

## Interface
- `G_MAIN_MIN`, 8: minimum main-green duration, cycles
- `G_SIDE`, 6: side-green duration, cycles
- `Y_TIME`, 3: yellow duration (both roads), cycles
- `RED_CLR`, 1: all-red clearance duration, cycles
- `WALK_TIME`, 5: pedestrian walk duration, cycles
- `TW`, 8: phase timer width; every duration must be < 2^TW
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset)
- `car_side` in 1: side-road vehicle present, level, synchronous to `clk`
- `ped_req` in 1: pedestrian request, 1-cycle pulse from the button-press FSM
- `main_light` out 3: {R,Y,G} one-hot, main road
- `side_light` out 3: {R,Y,G} one-hot, side road
- `walk` out 1: pedestrian walk lamp
- `ped_pending` out 1: latched, unserved pedestrian request
- `state` out 3: current state encoding, for debug

## Operation
- States (encoding): MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_A=2, WALK=3, SIDE_GREEN=4, SIDE_YELLOW=5, ALL_RED_B=6. Code 7 is illegal and goes to ALL_RED_B on the next edge, with all-red outputs.
- Moore outputs, decoded from the state register:
  - MAIN_GREEN: main G, side R
  - MAIN_YELLOW: main Y, side R
  - SIDE_GREEN: side G, main R
  - SIDE_YELLOW: side Y, main R
  - ALL_RED_A, ALL_RED_B: both R
  - WALK: both R, `walk`=1
- Phase timer (TW bits): loaded with duration-1 on entry to each state and decrements each cycle. A state is done when the timer reads 0. A duration parameter of 0 is treated as 1.
- Transitions:
  - MAIN_GREEN: done and (`car_side` | `ped_pending`) → MAIN_YELLOW. If done with no demand, hold MAIN_GREEN with the timer at 0.
  - MAIN_YELLOW: done → ALL_RED_A.
  - ALL_RED_A: done → WALK if `ped_pending`, else SIDE_GREEN if `car_side`, else ALL_RED_B.
  - WALK: done → SIDE_GREEN if `car_side`, else ALL_RED_B.
  - SIDE_GREEN: done → SIDE_YELLOW. Fixed length; `car_side` dropping does not shorten it.
  - SIDE_YELLOW: done → ALL_RED_B.
  - ALL_RED_B: done → MAIN_GREEN.
- `ped_pending`:
  - Set on the edge after `ped_req`=1.
  - Cleared on the edge that enters WALK. If set and clear coincide, clear wins; that request is served by the walk now starting.
  - `ped_req` is ignored while in WALK.
- Reset (async, `rst`=0): state MAIN_GREEN, timer G_MAIN_MIN-1, `main_light`=001, `side_light`=100, `walk`=0, `ped_pending`=0, `state`=0.
- Reset asserted mid-phase aborts the phase immediately: outputs go to their reset values with no yellow or clearance.

## Timing
- The state and timer update on the rising `clk` edge. Outputs change on that same edge.
- A state with duration D is occupied for exactly D cycles, except MAIN_GREEN, which is occupied for ≥ G_MAIN_MIN cycles.
- Demand is sampled only when MAIN_GREEN is done. Demand arriving earlier takes effect at the end of the minimum green. Demand arriving later is acted on at the next edge, so MAIN_YELLOW starts 1 cycle after demand.
- `car_side` is sampled at decision points only; it is not latched.
- First exit from MAIN_GREEN after reset release is no earlier than edge G_MAIN_MIN.

## Configuration
- `TRAFFIC_PED_WALK_EN` defined: pedestrian logic is present exactly as described above.
- `TRAFFIC_PED_WALK_EN` undefined:
  - `ped_req` is ignored.
  - `ped_pending` and `walk` are tied to 0.
  - WALK is unreachable.
  - State encoding and all other timing are unchanged.

## Test plan
- Reset, then `car_side`=0, `ped_req`=0 for 50 cycles → MAIN_GREEN held throughout: `main_light`=001, `side_light`=100, `state`=0.
- `car_side`=1 from cycle 2 onward (default parameters) → main G 8 cycles, main Y 3, all-red 1, side G 6, side Y 3, all-red 1, then MAIN_GREEN again. Full loop is 22 cycles.
- One `ped_req` pulse at cycle 3, `car_side`=0:
  - `ped_pending`=1 from cycle 4.
  - MAIN_YELLOW at cycle 8, ALL_RED_A at 11.
  - WALK with `walk`=1 for cycles 12–16, and `ped_pending` back to 0 at cycle 12.
  - ALL_RED_B at 17, MAIN_GREEN at 18.
- `ped_req` and `car_side`=1 both at cycle 3 → WALK for 5 cycles, then SIDE_GREEN for 6 cycles. A second `ped_req` during WALK leaves `ped_pending`=0.
- `rst`=0 asserted mid SIDE_GREEN, asynchronously between edges → `main_light`=001, `side_light`=100, `walk`=0 immediately. After release, the minimum green is a full 8 cycles.
- Build without `TRAFFIC_PED_WALK_EN`, pulse `ped_req` with `car_side`=0 → no state change for 50 cycles; `walk` and `ped_pending` stay 0.
